// File: rtl/sccb_init_seq.sv
// SCCB register-table initialiser: walks a sync-ROM table of write, verify, delay and end
// entries, drives an external SCCB master, and reports a successful finish or the first failure.
//
// state    | meaning
// IDLE     | waiting for go
// FETCH    | ROM address presented, data arrives next cycle
// DECODE   | entry latched, branch on cmd
// ISSUE    | one-cycle sccb_start for the current phase
// WAIT_HI  | waiting for the master to raise busy (timeout armed)
// WAIT_LO  | waiting for the master to drop busy (same timeout)
// GAP      | idle spacing after a transaction, then advance the phase
// CHECK    | compare read-back data against the written data
// DELAY    | counting down an entry delay
// FINISH   | done pulse
// FAIL     | error latched, return to IDLE
module sccb_init_seq #(
  parameter int TBL_AW    = 8,
  parameter int GAP_CYC   = 16,
  parameter int MAX_RETRY = 2,
  parameter int TO_CYC    = 2**20
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              go,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [27:0]       tbl_data,
  output logic              sccb_start,
  output logic [25:0]       sccb_datain,
  input  logic              sccb_busy,
  input  logic [7:0]        sccb_rdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [TBL_AW-1:0] err_idx,
  output logic [1:0]        err_code
);

  localparam logic [1:0] CMD_WR  = 2'b00;
  localparam logic [1:0] CMD_WV  = 2'b01;
  localparam logic [1:0] CMD_DLY = 2'b10;

  localparam logic [1:0] EC_TO   = 2'b01;
  localparam logic [1:0] EC_VFY  = 2'b10;
  localparam logic [1:0] EC_OVR  = 2'b11;

  localparam logic [31:0]       TO_LOAD  = 32'(TO_CYC - 1);
  localparam logic [31:0]       GAP_LOAD = 32'(GAP_CYC);
  localparam logic [7:0]        MAX_R    = 8'(MAX_RETRY);
  localparam logic [TBL_AW-1:0] ADDR_ONE = {{(TBL_AW-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT_HI, S_WAIT_LO,
    S_GAP, S_CHECK, S_DELAY, S_FINISH, S_FAIL
  } state_t;

  // phase encoding doubles as the SCCB mode field
  typedef enum logic [1:0] {PH_W = 2'b00, PH_R1 = 2'b01, PH_R2 = 2'b10} phase_t;

  state_t            state, state_nx;
  phase_t            phase, phase_nx;
  logic [31:0]       cnt, cnt_nx;
  logic [7:0]        retry, retry_nx;
  logic [TBL_AW-1:0] addr_nx;
  logic [1:0]        cmd_q;
  logic [6:0]        id_q;
  logic [15:0]       sd_q;
  logic [7:0]        rdata_q;
  logic              adv, fail_nx;
  logic [1:0]        code_nx;
  logic [6:0]        id_src;
  logic [15:0]       sd_src;
  logic              unused_bits;

  assign unused_bits = ^{tbl_data[25:24], tbl_data[16]};

  // DECODE issues straight from the ROM output, later phases from the latched copy
  assign id_src = (state == S_DECODE) ? tbl_data[23:17] : id_q;
  assign sd_src = (state == S_DECODE) ? tbl_data[15:0]  : sd_q;

  assign sccb_start = (state == S_ISSUE);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_FINISH);

  always_comb begin
    state_nx = state;
    phase_nx = phase;
    cnt_nx   = cnt;
    retry_nx = retry;
    addr_nx  = tbl_addr;
    adv      = 1'b0;
    fail_nx  = 1'b0;
    code_nx  = 2'b00;
    unique case (state)
      S_IDLE: begin
        if (go) begin
          state_nx = S_FETCH;
          addr_nx  = '0;
          retry_nx = '0;
        end
      end
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: begin
        unique case (tbl_data[27:26])
          CMD_WR, CMD_WV: begin
            state_nx = S_ISSUE;
            phase_nx = PH_W;
          end
          CMD_DLY: begin
            state_nx = S_DELAY;
            cnt_nx   = {16'd0, tbl_data[15:0]};
          end
          default: state_nx = S_FINISH;
        endcase
      end
      S_ISSUE: begin
        state_nx = S_WAIT_HI;
        cnt_nx   = TO_LOAD;
      end
      S_WAIT_HI: begin
        if (sccb_busy) begin
          state_nx = S_WAIT_LO;
          cnt_nx   = cnt - 32'd1;
        end else if (cnt <= 32'd1) begin
          fail_nx = 1'b1;
          code_nx = EC_TO;
        end else begin
          cnt_nx = cnt - 32'd1;
        end
      end
      S_WAIT_LO: begin
        if (!sccb_busy) begin
          state_nx = S_GAP;
          cnt_nx   = GAP_LOAD;
        end else if (cnt <= 32'd1) begin
          fail_nx = 1'b1;
          code_nx = EC_TO;
        end else begin
          cnt_nx = cnt - 32'd1;
        end
      end
      S_GAP: begin
        if (cnt <= 32'd1) begin
          unique case (phase)
            PH_W: begin
              if (cmd_q == CMD_WV) begin
                state_nx = S_ISSUE;
                phase_nx = PH_R1;
              end else begin
                adv = 1'b1;
              end
            end
            PH_R1: begin
              state_nx = S_ISSUE;
              phase_nx = PH_R2;
            end
            default: state_nx = S_CHECK;
          endcase
        end else begin
          cnt_nx = cnt - 32'd1;
        end
      end
      S_CHECK: begin
        if (rdata_q == sd_q[7:0]) begin
          adv = 1'b1;
        end else if (retry < MAX_R) begin
          retry_nx = retry + 8'd1;
          state_nx = S_ISSUE;
          phase_nx = PH_W;
        end else begin
          fail_nx = 1'b1;
          code_nx = EC_VFY;
        end
      end
      S_DELAY: begin
        if (cnt == 32'd0) adv = 1'b1;
        else cnt_nx = cnt - 32'd1;
      end
      S_FINISH: state_nx = S_IDLE;
      S_FAIL:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase

    // advancing past the last table slot is an overrun, not a wrap
    if (adv) begin
      if (&tbl_addr) begin
        fail_nx = 1'b1;
        code_nx = EC_OVR;
      end else begin
        addr_nx  = tbl_addr + ADDR_ONE;
        retry_nx = '0;
        state_nx = S_FETCH;
      end
    end
    if (fail_nx) state_nx = S_FAIL;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= S_IDLE;
      phase       <= PH_W;
      cnt         <= '0;
      retry       <= '0;
      tbl_addr    <= '0;
      cmd_q       <= '0;
      id_q        <= '0;
      sd_q        <= '0;
      rdata_q     <= '0;
      sccb_datain <= '0;
      error       <= 1'b0;
      err_idx     <= '0;
      err_code    <= 2'b00;
    end else begin
      state    <= state_nx;
      phase    <= phase_nx;
      cnt      <= cnt_nx;
      retry    <= retry_nx;
      tbl_addr <= addr_nx;
      if (state == S_DECODE) begin
        cmd_q <= tbl_data[27:26];
        id_q  <= tbl_data[23:17];
        sd_q  <= tbl_data[15:0];
      end
      if (state == S_GAP && phase == PH_R2 && cnt == GAP_LOAD) rdata_q <= sccb_rdata;
      if (state_nx == S_ISSUE) sccb_datain <= {phase_nx, id_src, 1'b0, sd_src};
      if (state == S_IDLE && go) error <= 1'b0;
      if (fail_nx) begin
        error    <= 1'b1;
        err_idx  <= tbl_addr;
        err_code <= code_nx;
      end
    end
  end

endmodule

// File: tb/tb_sccb_init_seq.sv
// Bench for sccb_init_seq: sync-ROM model, behavioural SCCB master with configurable
// latency, hang and read corruption, and a queue of expected sccb_datain words.
module tb_sccb_init_seq;

  localparam int AW  = 3;
  localparam int GAP = 4;
  localparam int MR  = 2;
  localparam int TO  = 64;

  logic          clk = 1'b0;
  logic          rstn, go;
  logic [AW-1:0] tbl_addr;
  logic [27:0]   tbl_data;
  logic          sccb_start;
  logic [25:0]   sccb_datain;
  logic          sccb_busy;
  logic [7:0]    sccb_rdata;
  logic          busy, done, error;
  logic [AW-1:0] err_idx;
  logic [1:0]    err_code;

  sccb_init_seq #(.TBL_AW(AW), .GAP_CYC(GAP), .MAX_RETRY(MR), .TO_CYC(TO)) dut (
    .clk(clk), .rstn(rstn), .go(go), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .sccb_start(sccb_start), .sccb_datain(sccb_datain), .sccb_busy(sccb_busy),
    .sccb_rdata(sccb_rdata), .busy(busy), .done(done), .error(error),
    .err_idx(err_idx), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // sync ROM
  logic [27:0] rom [8];
  always @(posedge clk) tbl_data <= rom[tbl_addr];

  // ignored entry bits are filled with ones/garbage so that decode must skip them
  function automatic logic [27:0] e_xfer(input logic [1:0] cmd, input logic [6:0] id,
                                         input logic [7:0] sub, input logic [7:0] dat);
    return {cmd, 2'b11, id, 1'b1, sub, dat};
  endfunction
  function automatic logic [27:0] e_dly(input logic [15:0] d);
    return {2'b10, 10'h2A5, d};
  endfunction
  function automatic logic [27:0] e_end();
    return {2'b11, 26'h0};
  endfunction
  function automatic logic [25:0] x_din(input logic [1:0] mode, input logic [6:0] id,
                                        input logic [7:0] sub, input logic [7:0] dat);
    return {mode, id, 1'b0, sub, dat};
  endfunction

  task automatic clr_rom();
    for (int i = 0; i < 8; i++) rom[i] = e_end();
  endtask

  // SCCB master model and scoreboard consumer
  logic [25:0] sb[$];
  bit          hang = 0;
  bit          skip_hold = 0;
  logic [7:0]  corrupt = 8'h00;
  logic [7:0]  wdata = 8'h00;
  logic [25:0] cur_din = '0;
  int          busy_len = 20;
  int          pend = 0;
  int          hold = 0;
  int          since_fall = 100;
  int          cyc_now = 0;
  int          t_start = 0;
  int          t_err = 0;
  int          n_start = 0;
  int          n_done = 0;
  logic        err_q = 1'b0;

  always @(negedge clk) begin
    cyc_now++;
    if (error && !err_q) t_err = cyc_now;
    err_q = error;
    if (done) n_done++;
    if (sccb_start) begin
      n_start++;
      t_start = cyc_now;
      chk("start_gap", (since_fall >= GAP && !sccb_busy && pend == 0) ? 32'd1 : 32'd0, 32'd1);
      chk("start_expected", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (sb.size() > 0) chk("datain", 32'(sccb_datain), 32'(sb.pop_front()));
      cur_din = sccb_datain;
      if (sccb_datain[25:24] == 2'b00) wdata = sccb_datain[7:0];
      if (!hang) pend = 2;
    end
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        sccb_busy = 1'b1;
        hold = busy_len;
      end
    end else if (sccb_busy) begin
      hold--;
      if (hold == 0) begin
        sccb_busy = 1'b0;
        since_fall = 0;
        if (!skip_hold) chk("datain_hold", 32'(sccb_datain), 32'(cur_din));
        if (cur_din[25:24] == 2'b10) sccb_rdata = wdata ^ corrupt;
      end
    end else if (since_fall < 1000) begin
      since_fall++;
    end
  end

  task automatic start_go();
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
  endtask

  task automatic wait_end(input int max_cyc, output int cyc);
    cyc = 0;
    while (!done && !error && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
    end
    chk("run_ended", (done || error) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_busy();
    for (int i = 0; i < 50 && !sccb_busy; i++) @(negedge clk);
    chk("slave_busy_seen", 32'(sccb_busy), 32'd1);
  endtask

  task automatic finish_run(input string tag, input bit ok, input logic [1:0] code,
                            input logic [AW-1:0] idx, input int nd0, input int ns0,
                            input int starts);
    chk({tag, "_done"}, 32'(done), 32'(ok));
    chk({tag, "_error"}, 32'(error), 32'(!ok));
    if (!ok) begin
      chk({tag, "_err_code"}, 32'(err_code), 32'(code));
      chk({tag, "_err_idx"}, 32'(err_idx), 32'(idx));
    end
    @(negedge clk); #1;
    chk({tag, "_done_width"}, 32'(done), 32'd0);
    chk({tag, "_done_count"}, 32'(n_done - nd0), 32'(ok));
    chk({tag, "_start_count"}, 32'(n_start - ns0), 32'(starts));
    chk({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
    repeat (10) @(negedge clk);
  endtask

  task automatic run_expect(input string tag, input bit ok, input logic [1:0] code,
                            input logic [AW-1:0] idx, input int starts, output int cyc);
    int nd0, ns0;
    nd0 = n_done;
    ns0 = n_start;
    start_go();
    wait_end(3000, cyc);
    finish_run(tag, ok, code, idx, nd0, ns0, starts);
  endtask

  task automatic push_wv(input logic [6:0] id, input logic [7:0] sub, input logic [7:0] dat);
    sb.push_back(x_din(2'b00, id, sub, dat));
    sb.push_back(x_din(2'b01, id, sub, dat));
    sb.push_back(x_din(2'b10, id, sub, dat));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int cyc, nd0, ns0;
    rstn = 1'b0; go = 1'b0; sccb_busy = 1'b0; sccb_rdata = 8'h00;
    clr_rom();
    repeat (3) @(negedge clk);
    chk("rst_tbl_addr", 32'(tbl_addr), 32'd0);
    chk("rst_start", 32'(sccb_start), 32'd0);
    chk("rst_datain", 32'(sccb_datain), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    // single write
    clr_rom();
    rom[0] = e_xfer(2'b00, 7'h78, 8'h08, 8'h82);
    sb.push_back(26'h0F00882);
    run_expect("s1", 1'b1, 2'b00, '0, 1, cyc);

    // write-verify with matching read-back
    clr_rom();
    corrupt = 8'h00;
    rom[0] = e_xfer(2'b01, 7'h21, 8'h3A, 8'hC5);
    push_wv(7'h21, 8'h3A, 8'hC5);
    run_expect("s2", 1'b1, 2'b00, '0, 3, cyc);

    // write-verify that never matches: three full attempts then verify error
    clr_rom();
    corrupt = 8'h5A;
    rom[0] = e_xfer(2'b01, 7'h42, 8'h11, 8'h99);
    for (int i = 0; i <= MR; i++) push_wv(7'h42, 8'h11, 8'h99);
    run_expect("s3", 1'b0, 2'b10, 3'd0, 9, cyc);
    corrupt = 8'h00;

    // delay entry: go edge -> FETCH, DECODE, DELAY x1001, FETCH, DECODE, FINISH
    clr_rom();
    rom[0] = e_dly(16'd1000);
    run_expect("s4", 1'b1, 2'b00, '0, 0, cyc);
    chk("s4_cycles", 32'(cyc), 32'd1005);

    // master never raises busy
    clr_rom();
    hang = 1'b1;
    rom[0] = e_xfer(2'b00, 7'h05, 8'h06, 8'h07);
    sb.push_back(x_din(2'b00, 7'h05, 8'h06, 8'h07));
    run_expect("s5", 1'b0, 2'b01, 3'd0, 1, cyc);
    chk("s5_timeout_cycles", 32'(t_err - t_start), 32'(TO));
    hang = 1'b0;

    // mixed table exercising every command
    clr_rom();
    rom[0] = e_xfer(2'b00, 7'h10, 8'h01, 8'hA1);
    rom[1] = e_dly(16'd3);
    rom[2] = e_xfer(2'b01, 7'h11, 8'h02, 8'hB2);
    rom[3] = e_xfer(2'b00, 7'h12, 8'h03, 8'h0C);
    sb.push_back(x_din(2'b00, 7'h10, 8'h01, 8'hA1));
    push_wv(7'h11, 8'h02, 8'hB2);
    sb.push_back(x_din(2'b00, 7'h12, 8'h03, 8'h0C));
    run_expect("mix", 1'b1, 2'b00, '0, 5, cyc);

    // table without END runs off the last slot
    for (int i = 0; i < 8; i++) rom[i] = e_dly(16'd0);
    run_expect("ovr", 1'b0, 2'b11, 3'd7, 0, cyc);

    // go pulsed mid-run is ignored
    clr_rom();
    rom[0] = e_xfer(2'b00, 7'h33, 8'h44, 8'h55);
    rom[1] = e_xfer(2'b00, 7'h34, 8'h45, 8'h56);
    sb.push_back(x_din(2'b00, 7'h33, 8'h44, 8'h55));
    sb.push_back(x_din(2'b00, 7'h34, 8'h45, 8'h56));
    nd0 = n_done;
    ns0 = n_start;
    start_go();
    wait_busy();
    chk("busy_midrun", 32'(busy), 32'd1);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    wait_end(3000, cyc);
    finish_run("goign", 1'b1, 2'b00, '0, nd0, ns0, 2);

    // reset during WAIT_LO, then a fresh run from entry 0
    sb.push_back(x_din(2'b00, 7'h33, 8'h44, 8'h55));
    skip_hold = 1'b1;
    ns0 = n_start;
    start_go();
    wait_busy();
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("s6_tbl_addr", 32'(tbl_addr), 32'd0);
    chk("s6_start", 32'(sccb_start), 32'd0);
    chk("s6_datain", 32'(sccb_datain), 32'd0);
    chk("s6_busy", 32'(busy), 32'd0);
    chk("s6_done", 32'(done), 32'd0);
    chk("s6_error", 32'(error), 32'd0);
    chk("s6_err_idx", 32'(err_idx), 32'd0);
    chk("s6_err_code", 32'(err_code), 32'd0);
    rstn = 1'b1;
    for (int i = 0; i < 200 && sccb_busy; i++) @(negedge clk);
    chk("s6_slave_idle", 32'(sccb_busy), 32'd0);
    repeat (10) @(negedge clk);
    chk("s6_starts_before_rst", 32'(n_start - ns0), 32'd1);
    chk("s6_sb_after_rst", 32'(sb.size()), 32'd0);
    skip_hold = 1'b0;
    sb.push_back(x_din(2'b00, 7'h33, 8'h44, 8'h55));
    sb.push_back(x_din(2'b00, 7'h34, 8'h45, 8'h56));
    run_expect("s6b", 1'b1, 2'b00, '0, 2, cyc);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
